register_file_bank: RTL and testbench

- Register storage fed directly by the register-address stage; consumes its destination address (DA) and source addresses (AA, BA).
- Provides two read ports (A, B) and one synchronous write port to the datapath function unit.
- Holds 2^ADDR_WIDTH registers:
  - lower half are architectural (R0..R7 at defaults);
  - upper half are temporaries (R8..R15), used by multi-cycle instruction sequences.
- Includes write-through bypass, bulk clearing of the temporary bank, and a registered write-acknowledge.

---
 rtl/register_file_bank.sv | 100 ++++++++++
 tb/tb_register_file_bank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/register_file_bank.sv
// Register file: 2^ADDR_WIDTH registers, two combinational read ports, one write port, temporary-bank clear.
// Latency: reads are zero-cycle (with write-through bypass); writes commit on the edge; WACK/WADDR_Q one cycle later.
// Backpressure: none; every write is accepted on the edge it is presented (unless discarded for R0 or reset).
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   DA, RW, D      destination address, write enable, write data
//   AA, BA         read addresses for ports A and B
//   TCLR           clear every register in the upper (temporary) half
//   A, B           read data for AA / BA
//   WACK, WADDR_Q  registered write acknowledge and address of the last committed write
module register_file_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit R0_ZERO    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] DA,
  input  logic [ADDR_WIDTH-1:0] AA,
  input  logic [ADDR_WIDTH-1:0] BA,
  input  logic                  RW,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  TCLR,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic                  WACK,
  output logic [ADDR_WIDTH-1:0] WADDR_Q
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NREG];
  logic [DATA_WIDTH-1:0] mem_d [NREG];
  logic                  wack_q, wack_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  wr_commit;

  // A write to R0 is dropped entirely when R0 is hardwired to zero.
  assign wr_commit = RW && !(R0_ZERO && (DA == '0));

  // Read mux shared by both ports. Priority: hardwired R0, then bypass of the
  // in-flight write, then the pending temporary clear, then stored contents.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = mem_q[addr];
    if (R0_ZERO && (addr == '0)) begin
      val = '0;
    end else if (wr_commit && (DA == addr)) begin
      val = D;
    end else if (TCLR && addr[ADDR_WIDTH-1]) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    A = read_port(AA);
    B = read_port(BA);
  end

  // Next-state for storage: the clear is applied first so that a write into
  // the temporary bank on the same edge survives.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
      if (TCLR && (i >= NREG / 2)) begin
        mem_d[i] = '0;
      end
    end
    if (wr_commit) begin
      mem_d[DA] = D;
    end
  end

  always_comb begin
    wack_d  = wr_commit;
    waddr_d = wr_commit ? DA : waddr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      wack_q  <= 1'b0;
      waddr_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wack_q  <= wack_d;
      waddr_q <= waddr_d;
    end
  end

  assign WACK    = wack_q;
  assign WADDR_Q = waddr_q;

endmodule

// File: tb/tb_register_file_bank.sv
// Testbench for register_file_bank: vector table applied in sequence, registered outputs via scoreboard queue.
// Latency: A/B checked before each edge, WACK/WADDR_Q checked one cycle after the vector.
// Backpressure: not applicable.
module tb_register_file_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  DA, AA, BA;
  logic        RW, TCLR;
  logic [15:0] D;
  logic [15:0] A, B;
  logic        WACK;
  logic [3:0]  WADDR_Q;

  register_file_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .R0_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .DA(DA), .AA(AA), .BA(BA), .RW(RW), .D(D),
    .TCLR(TCLR), .A(A), .B(B), .WACK(WACK), .WADDR_Q(WADDR_Q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rw;
    logic        tclr;
    logic [3:0]  da;
    logic [3:0]  aa;
    logic [3:0]  ba;
    logic [15:0] d;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_wack;
    logic [3:0]  exp_waddr;
  } vec_t;

  typedef struct {
    logic       wack;
    logic [3:0] waddr;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(logic rst, logic rw, logic tclr, logic [3:0] da, logic [3:0] aa,
                              logic [3:0] ba, logic [15:0] d, logic [15:0] ea, logic [15:0] eb,
                              logic ew, logic [3:0] ewa);
    vec_t v;
    v.rst = rst; v.rw = rw; v.tclr = tclr; v.da = da; v.aa = aa; v.ba = ba; v.d = d;
    v.exp_a = ea; v.exp_b = eb; v.exp_wack = ew; v.exp_waddr = ewa;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, check combinational reads, then let the edge
  // commit and compare the registered outputs against the queued expectation.
  task automatic apply(input vec_t v, input int idx);
    sb_t e, got;
    @(negedge clk);
    reset = v.rst; RW = v.rw; TCLR = v.tclr; DA = v.da; AA = v.aa; BA = v.ba; D = v.d;
    #1;
    check($sformatf("v%0d A[%0d]", idx, v.aa), A, v.exp_a);
    check($sformatf("v%0d B[%0d]", idx, v.ba), B, v.exp_b);
    e.wack = v.exp_wack; e.waddr = v.exp_waddr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL v%0d scoreboard: queue empty, expected one entry", idx);
    end else begin
      got = sb_q.pop_front();
      check($sformatf("v%0d WACK", idx), {15'd0, WACK}, {15'd0, got.wack});
      check($sformatf("v%0d WADDR_Q", idx), {12'd0, WADDR_Q}, {12'd0, got.waddr});
    end
  endtask

  logic [15:0] wdata [16];

  initial begin
    reset = 1'b1; RW = 1'b0; TCLR = 1'b0; DA = '0; AA = '0; BA = '0; D = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset WACK", {15'd0, WACK}, 16'd0);
    check("reset WADDR_Q", {12'd0, WADDR_Q}, 16'd0);

    // All addresses read 0 after reset.
    for (int i = 0; i < 16; i++) begin
      add(0, 0, 0, 4'd0, 4'(i), 4'(15 - i), 16'h0, 16'h0, 16'h0, 0, 4'd0);
    end
    //  rst rw tclr da    aa    ba    d         A         B         wack waddr
    add(0, 1, 0, 4'd3,  4'd1,  4'd2,  16'hBEEF, 16'h0000, 16'h0000, 1, 4'd3);
    add(0, 0, 0, 4'd0,  4'd3,  4'd3,  16'h0000, 16'hBEEF, 16'hBEEF, 0, 4'd3);
    add(0, 1, 0, 4'd5,  4'd5,  4'd5,  16'h1234, 16'h1234, 16'h1234, 1, 4'd5);
    add(0, 0, 0, 4'd0,  4'd5,  4'd3,  16'h0000, 16'h1234, 16'hBEEF, 0, 4'd5);
    add(0, 1, 0, 4'd0,  4'd0,  4'd0,  16'hFFFF, 16'h0000, 16'h0000, 0, 4'd5);
    add(0, 0, 0, 4'd0,  4'd0,  4'd5,  16'h0000, 16'h0000, 16'h1234, 0, 4'd5);
    add(0, 1, 0, 4'd2,  4'd2,  4'd9,  16'hAAAA, 16'hAAAA, 16'h0000, 1, 4'd2);
    add(0, 1, 0, 4'd9,  4'd2,  4'd9,  16'h5555, 16'hAAAA, 16'h5555, 1, 4'd9);
    add(0, 0, 1, 4'd0,  4'd2,  4'd9,  16'h0000, 16'hAAAA, 16'h0000, 0, 4'd9);
    add(0, 0, 0, 4'd0,  4'd2,  4'd9,  16'h0000, 16'hAAAA, 16'h0000, 0, 4'd9);
    add(0, 1, 0, 4'd10, 4'd10, 4'd12, 16'h7777, 16'h7777, 16'h0000, 1, 4'd10);
    add(0, 1, 1, 4'd12, 4'd12, 4'd10, 16'h0F0F, 16'h0F0F, 16'h0000, 1, 4'd12);
    add(0, 0, 0, 4'd0,  4'd12, 4'd10, 16'h0000, 16'h0F0F, 16'h0000, 0, 4'd12);
    add(0, 1, 1, 4'd4,  4'd4,  4'd12, 16'h4444, 16'h4444, 16'h0000, 1, 4'd4);
    add(0, 0, 0, 4'd0,  4'd4,  4'd12, 16'h0000, 16'h4444, 16'h0000, 0, 4'd4);
    add(1, 1, 0, 4'd4,  4'd3,  4'd2,  16'h9999, 16'hBEEF, 16'hAAAA, 0, 4'd0);
    add(0, 0, 0, 4'd0,  4'd4,  4'd3,  16'h0000, 16'h0000, 16'h0000, 0, 4'd0);
    add(0, 1, 0, 4'd15, 4'd15, 4'd14, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 4'd15);
    add(0, 0, 0, 4'd0,  4'd15, 4'd8,  16'h0000, 16'hFFFF, 16'h0000, 0, 4'd15);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Walk every writable register with random data, then read all back in pairs.
    wdata[0] = 16'h0000;
    for (int i = 1; i < 16; i++) begin
      vec_t v;
      wdata[i] = 16'($urandom);
      v = '{rst: 0, rw: 1, tclr: 0, da: 4'(i), aa: 4'(i), ba: 4'd0, d: wdata[i],
            exp_a: wdata[i], exp_b: 16'h0, exp_wack: 1, exp_waddr: 4'(i)};
      apply(v, 100 + i);
    end
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = '{rst: 0, rw: 0, tclr: 0, da: 4'd0, aa: 4'(i), ba: 4'(15 - i), d: 16'h0,
            exp_a: wdata[i], exp_b: wdata[15 - i], exp_wack: 0, exp_waddr: 4'd15};
      apply(v, 200 + i);
    end

    // Temporary clear after the walk: lower half retained, upper half zero.
    begin
      vec_t v;
      v = '{rst: 0, rw: 0, tclr: 1, da: 4'd0, aa: 4'd7, ba: 4'd8, d: 16'h0,
            exp_a: wdata[7], exp_b: 16'h0, exp_wack: 0, exp_waddr: 4'd15};
      apply(v, 300);
      for (int i = 0; i < 8; i++) begin
        v = '{rst: 0, rw: 0, tclr: 0, da: 4'd0, aa: 4'(i), ba: 4'(i + 8), d: 16'h0,
              exp_a: wdata[i], exp_b: 16'h0, exp_wack: 0, exp_waddr: 4'd15};
        apply(v, 310 + i);
      end
    end

    if (sb_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
